// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle.
// Groups the core request/response handshake, the data memory port and the
// completion counters. 'slave' is the load/store unit's view; 'master' is the
// view of the core plus data memory that surround it.
//   req_*   : core request (valid/ready, write flag, two addresses, store data)
//   rsp_*   : load response (valid/ready, two read words)
//   mem_*   : data memory port (enable, read/write-not, addresses, data)
//   *_cnt   : completed load/store counters
interface load_store_unit_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
);
  localparam int unsigned CNT_W = 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr1;
  logic [ADDR_W-1:0] req_addr2;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data1;
  logic [DATA_W-1:0] rsp_data2;
  logic              mem_enable;
  logic              mem_read_writenot;
  logic [ADDR_W-1:0] mem_address1;
  logic [ADDR_W-1:0] mem_address2;
  logic [ADDR_W-1:0] mem_write_address;
  logic [DATA_W-1:0] mem_in_data;
  logic [DATA_W-1:0] mem_out_data1;
  logic [DATA_W-1:0] mem_out_data2;
  logic [CNT_W-1:0]  load_cnt;
  logic [CNT_W-1:0]  store_cnt;

  modport slave (
    input  req_valid, req_write, req_addr1, req_addr2, req_wdata,
    input  rsp_ready, mem_out_data1, mem_out_data2,
    output req_ready, rsp_valid, rsp_data1, rsp_data2,
    output mem_enable, mem_read_writenot, mem_address1, mem_address2,
    output mem_write_address, mem_in_data, load_cnt, store_cnt
  );

  modport master (
    output req_valid, req_write, req_addr1, req_addr2, req_wdata,
    output rsp_ready, mem_out_data1, mem_out_data2,
    input  req_ready, rsp_valid, rsp_data1, rsp_data2,
    input  mem_enable, mem_read_writenot, mem_address1, mem_address2,
    input  mem_write_address, mem_in_data, load_cnt, store_cnt
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, drives a single-cycle
// data memory access, and for loads returns two read words via a valid/ready
// response. Counts completed loads and stores (8-bit, wrapping).
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-low reset
//   bus  : load_store_unit_if.slave (request, response, memory, counters)
module load_store_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_store_done;
  logic              w_load_done;
  logic              w_write_nxt;
  logic              w_req_ready_nxt;
  logic              w_rsp_valid_nxt;
  logic              w_mem_enable_nxt;
  logic              w_mem_rwn_nxt;

  logic              r_write;
  logic [ADDR_W-1:0] r_addr1;
  logic [ADDR_W-1:0] r_addr2;
  logic [DATA_W-1:0] r_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_mem_enable;
  logic              r_mem_rwn;
  logic [DATA_W-1:0] r_rsp_data1;
  logic [DATA_W-1:0] r_rsp_data2;
  logic [CNT_W-1:0]  r_load_cnt;
  logic [CNT_W-1:0]  r_store_cnt;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state, completion strobes and next values of the registered outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_store_done = 1'b0;
    w_load_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_write) begin
          w_store_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_state_nxt  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_load_done = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Outputs are registered, so they are decoded from the state being entered
    w_write_nxt      = w_accept ? bus.req_write : r_write;
    w_req_ready_nxt  = (w_state_nxt == S_IDLE);
    w_rsp_valid_nxt  = (w_state_nxt == S_RESP);
    w_mem_enable_nxt = (w_state_nxt == S_ISSUE);
    w_mem_rwn_nxt    = !(w_mem_enable_nxt && w_write_nxt);
  end

  // Request latch, registered outputs, response capture and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write      <= 1'b0;
      r_addr1      <= '0;
      r_addr2      <= '0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_mem_enable <= 1'b0;
      r_mem_rwn    <= 1'b1;
      r_rsp_data1  <= '0;
      r_rsp_data2  <= '0;
      r_load_cnt   <= '0;
      r_store_cnt  <= '0;
    end else begin
      r_req_ready  <= w_req_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_mem_enable <= w_mem_enable_nxt;
      r_mem_rwn    <= w_mem_rwn_nxt;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr1 <= bus.req_addr1;
        r_addr2 <= bus.req_addr2;
        r_wdata <= bus.req_wdata;
      end
      if (w_load_done) begin
        r_rsp_data1 <= bus.mem_out_data1;
        r_rsp_data2 <= bus.mem_out_data2;
        r_load_cnt  <= r_load_cnt + CNT_W'(1);
      end
      if (w_store_done) r_store_cnt <= r_store_cnt + CNT_W'(1);
    end
  end

  // Memory address/data follow the latched request and hold between accesses
  assign bus.req_ready         = r_req_ready;
  assign bus.rsp_valid         = r_rsp_valid;
  assign bus.rsp_data1         = r_rsp_data1;
  assign bus.rsp_data2         = r_rsp_data2;
  assign bus.mem_enable        = r_mem_enable;
  assign bus.mem_read_writenot = r_mem_rwn;
  assign bus.mem_address1      = r_addr1;
  assign bus.mem_address2      = r_addr2;
  assign bus.mem_write_address = r_addr1;
  assign bus.mem_in_data       = r_wdata;
  assign bus.load_cnt          = r_load_cnt;
  assign bus.store_cnt         = r_store_cnt;
endmodule
